// File: rtl/inst_fifo_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// One entry carries the fetch PC, the instruction word and the fetch address-error flag.
package inst_fifo_pkg;

    localparam int unsigned INST_FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } inst_entry_t;

endpackage

// File: rtl/inst_fifo_mem.sv
// Entry storage for inst_fifo: one synchronous write port, one asynchronous read port.
// Contents are never reset; inst_fifo masks the read data while the queue is empty.
module inst_fifo_mem
    import inst_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = INST_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  inst_entry_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output inst_entry_t              rdata
);

    inst_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fifo.sv
// Instruction queue between fetch and decode: pointers, occupancy and flush control.
// Full/empty derive from the registered count only, so a pop cannot free space for a same-edge push.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = INST_FIFO_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [31:0]            push_pc,
    input  logic [31:0]            push_instr,
    input  logic                   push_adel,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [31:0]            pop_pc,
    output logic [31:0]            pop_instr,
    output logic                   pop_adel,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        full;
    logic        empty;
    logic        push_fire;
    logic        pop_fire;
    inst_entry_t wr_entry;
    inst_entry_t rd_entry;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_fire = push_valid & ~full;
    assign pop_fire  = pop_ready & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = push_pc;
        wr_entry.instr = push_instr;
        wr_entry.adel  = push_adel;
    end

    inst_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push_fire & ~flush),
        .waddr(wr_ptr_q),
        .wdata(wr_entry),
        .raddr(rd_ptr_q),
        .rdata(rd_entry)
    );

    // An empty queue presents a NOP so stale storage never reaches decode.
    always_comb begin
        pop_pc    = '0;
        pop_instr = '0;
        pop_adel  = 1'b0;
        if (!empty) begin
            pop_pc    = rd_entry.pc;
            pop_instr = rd_entry.instr;
            pop_adel  = rd_entry.adel;
        end
    end

    assign pop_valid  = ~empty;
    assign push_ready = ~full;
    assign count      = count_q;

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo against a queue-based reference model.
module tb_inst_fifo;
    import inst_fifo_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_adel;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic        pop_adel;
    logic [3:0]  count;

    int unsigned n_asserts = 0;
    int unsigned n_fails   = 0;

    inst_entry_t mq [$];

    inst_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_pc   (push_pc),
        .push_instr(push_instr),
        .push_adel (push_adel),
        .pop_valid (pop_valid),
        .pop_ready (pop_ready),
        .pop_pc    (pop_pc),
        .pop_instr (pop_instr),
        .pop_adel  (pop_adel),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        inst_entry_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        chk("count",      32'(count),      32'(mq.size()));
        chk("pop_valid",  32'(pop_valid),  32'(mq.size() != 0));
        chk("push_ready", 32'(push_ready), 32'(mq.size() != DEPTH));
        chk("pop_pc",     pop_pc,          h.pc);
        chk("pop_instr",  pop_instr,       h.instr);
        chk("pop_adel",   32'(pop_adel),   32'(h.adel));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ad, input logic pr, input logic fl);
        inst_entry_t e;
        bit pf, qf;
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        push_adel  = ad;
        pop_ready  = pr;
        flush      = fl;
        e.pc = pc;
        e.instr = ins;
        e.adel = ad;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            pf = pv && (mq.size() < DEPTH);
            qf = pr && (mq.size() > 0);
            if (qf) void'(mq.pop_front());
            if (pf) mq.push_back(e);
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        push_valid = 1'b0;
        push_pc = '0;
        push_instr = '0;
        push_adel = 1'b0;
        pop_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_pop_valid",  32'(pop_valid),  32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_pop_instr",  pop_instr,       32'h0);
        chk("rst_count",      32'(count),      32'd0);
        #3 rst = 1'b0;

        // Three boot PCs, then drain in order
        step(1, 32'hBFC00000, 32'h11110000, 0, 0, 0);
        step(1, 32'hBFC00004, 32'h11110004, 0, 0, 0);
        step(1, 32'hBFC00008, 32'h11110008, 0, 0, 0);
        chk("boot_count", 32'(count), 32'd3);
        chk("boot_head",  pop_pc,     32'hBFC00000);
        step(0, 0, 0, 0, 1, 0);
        chk("boot_pop2", pop_pc, 32'hBFC00004);
        step(0, 0, 0, 0, 1, 0);
        chk("boot_pop3", pop_pc, 32'hBFC00008);
        step(0, 0, 0, 0, 1, 0);
        chk("boot_empty", 32'(pop_valid), 32'd0);

        // Fill, then push against full with a same-cycle pop
        for (int unsigned i = 0; i < DEPTH; i++)
            step(1, 32'h80000000 + 4 * i, 32'hA0000000 + i, 0, 0, 0);
        chk("full_push_ready", 32'(push_ready), 32'd0);
        step(1, 32'h80000100, 32'hA00000FF, 0, 1, 0);
        chk("full_refused_count", 32'(count), 32'd7);
        chk("full_head", pop_pc, 32'h80000004);

        // Streaming push+pop across pointer wrap
        for (int unsigned i = 0; i < 20; i++)
            step(1, 32'h90000000 + 4 * i, 32'hB0000000 + i, 0, 1, 0);
        for (int unsigned i = 0; i < DEPTH; i++)
            step(0, 0, 0, 0, 1, 0);
        chk("stream_drained", 32'(count), 32'd0);

        // Flush with count 5 beats push and pop
        for (int unsigned i = 0; i < 5; i++)
            step(1, 32'hC0000000 + 4 * i, 32'hC1000000 + i, 0, 0, 0);
        chk("pre_flush_count", 32'(count), 32'd5);
        step(1, 32'hC0000100, 32'hC1000100, 0, 1, 1);
        chk("flush_count",     32'(count),      32'd0);
        chk("flush_pop_valid", 32'(pop_valid),  32'd0);
        chk("flush_pop_instr", pop_instr,       32'h0);
        chk("flush_push_ready", 32'(push_ready), 32'd1);

        // Address-error flag stays with its entry
        step(1, 32'hD0000000, 32'h24010001, 0, 0, 0);
        step(1, 32'hD0000004, 32'h3C01BFC0, 1, 0, 0);
        step(1, 32'hD0000008, 32'h24010002, 0, 0, 0);
        chk("adel_nb0", 32'(pop_adel), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("adel_flag",  32'(pop_adel), 32'd1);
        chk("adel_instr", pop_instr,     32'h3C01BFC0);
        step(0, 0, 0, 0, 1, 0);
        chk("adel_nb2", 32'(pop_adel), 32'd0);
        step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-cycle with count 4
        for (int unsigned i = 0; i < 4; i++)
            step(1, 32'hE0000000 + 4 * i, 32'hE1000000 + i, 0, 0, 0);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_pop_valid", 32'(pop_valid), 32'd0);
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_pop_instr", pop_instr,      32'h0);
        mq.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        step(1, 32'hF0000000, 32'hF1000000, 0, 0, 0);
        chk("post_rst_first", 32'(count), 32'd1);
        step(0, 0, 0, 0, 1, 0);

        // Random traffic against the model
        for (int unsigned i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), $urandom, $urandom, 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 Parameter DEPTH, default 8, queue entry count; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  discard all entries (exception, eret or branch redirect).
REQ-005 push_valid  input  1  fetch stage presents an instruction.
REQ-006 push_ready  output  1  queue can accept; equals not full.
REQ-007 push_pc  input  32  fetch PC.
REQ-008 push_instr  input  32  fetched instruction word.
REQ-009 push_adel  input  1  fetch address-error flag.
REQ-010 pop_valid  output  1  head entry valid; equals not empty.
REQ-011 pop_ready  input  1  decode stage consumes head (not stalled).
REQ-012 pop_pc  output  32  head PC.
REQ-013 pop_instr  output  32  head instruction word; drives the decoder instruction input.
REQ-014 pop_adel  output  1  head address-error flag.
REQ-015 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push fires when push_valid and push_ready are both high at a rising edge; the entry is written at the write pointer, which then advances.
REQ-017 Pop fires when pop_valid and pop_ready are both high at a rising edge; the read pointer advances.
REQ-018 No bypass: a pushed entry appears on pop_* one cycle after the push edge at the earliest.
REQ-019 push_ready is registered-state only: when full, push is refused even if a pop fires in the same cycle.
REQ-020 Simultaneous push and pop when neither full nor empty: both fire and count is unchanged.
REQ-021 Pointers wrap modulo DEPTH; full/empty come from count (count==DEPTH is full, count==0 is empty).
REQ-022 When pop_valid is low, pop_instr is 32'h0 (NOP), pop_pc is 32'h0 and pop_adel is 0.
REQ-023 pop_* are driven combinationally from the storage entry at the read pointer.
REQ-024 flush has priority over push and pop: at the edge, pointers and count clear to 0 and any same-cycle push or pop is dropped.
REQ-025 When flush is asserted, the next cycle shows pop_valid=0 and push_ready=1.
REQ-026 Entry order is strictly FIFO; an entry's pc, instr and adel stay bound together.
REQ-027 Push while full and pop while empty leave all state unchanged.

Reset
REQ-028 While rst is high: read pointer, write pointer and count are 0; pop_valid=0; push_ready=1; pop_instr=32'h0.
REQ-029 Storage array contents are not reset; they are invisible because of REQ-022.
REQ-030 Deasserting rst mid-stream leaves the queue empty; the first push is accepted on the first edge after release.

Structure
REQ-031 Shared package defines the entry struct (pc[31:0], instr[31:0], adel) and INST_FIFO_DEPTH_DEFAULT=8.
REQ-032 Storage is one sub-module, inst_fifo_mem: DEPTH x entry array with one synchronous write port and one asynchronous read port.
REQ-033 Control (pointers, count, flush) stays in inst_fifo; no further hierarchy.

Verification
REQ-034 Reset then push PCs 0xBFC00000, 0xBFC00004 and 0xBFC00008 with pop_ready=0 -> count=3 and pop_pc=0xBFC00000; the three pops return the same order.
REQ-035 Fill 8 entries with pop_ready=0 -> push_ready=0; a 9th push with pop_ready=1 in the same cycle is refused, the pop fires, and count=7.
REQ-036 Continuous push and pop for 20 cycles with increasing PCs -> no loss or duplication and correct order across pointer wrap.
REQ-037 Queue at count=5; assert flush together with push_valid and pop_ready -> next cycle count=0, pop_valid=0 and pop_instr=0.
REQ-038 Push an entry with push_adel=1 and instr 0x3C01BFC0 -> it pops with pop_adel=1 and the same instr; neighbouring entries have pop_adel=0.
REQ-039 Assert rst asynchronously mid-cycle with count=4 -> pop_valid falls immediately without waiting for a clock edge, and count reads 0.
